// File: rtl/w_mem_load_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module    : w_mem_load_ctrl_if
// Purpose   : Bundles the weight-word input stream (valid/ready/data) and the
//             CNN and FC weight-memory write ports of w_mem_load_ctrl.
// Ports     : in_valid/in_data (stream in), in_ready (stream back-pressure),
//             wr_enable_*/wr_addr_*/wr_data_* (CNN and FC write ports).
//             master : controller view (consumes stream, drives write ports)
//             slave  : environment view (drives stream, observes writes)
// Revision  : 1.0 - initial release
// ============================================================================
interface w_mem_load_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              wr_enable_cnn;
  logic [ADDR_W-1:0] wr_addr_cnn;
  logic [DATA_W-1:0] wr_data_cnn;
  logic              wr_enable_fc;
  logic [ADDR_W-1:0] wr_addr_fc;
  logic [DATA_W-1:0] wr_data_fc;

  modport master (
    input  in_valid, in_data,
    output in_ready,
    output wr_enable_cnn, wr_addr_cnn, wr_data_cnn,
    output wr_enable_fc, wr_addr_fc, wr_data_fc
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready,
    input  wr_enable_cnn, wr_addr_cnn, wr_data_cnn,
    input  wr_enable_fc, wr_addr_fc, wr_data_fc
  );
endinterface
`default_nettype wire

// File: rtl/w_mem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module    : w_mem_load_ctrl
// Purpose   : Weight-load sequencer. Accepts a stream of packed weight words
//             and turns each accepted beat into a registered write to either
//             the CNN or the FC weight-memory port, at consecutive addresses
//             from a base. Signals completion with a one-cycle done pulse.
// Ports     : clk, reset (async, active-low), clear (sync abort),
//             start, cfg_mode, cfg_base_addr, cfg_num_words (job setup),
//             bus (stream + write ports, master modport),
//             busy, done, words_written (status).
// Revision  : 1.0 - initial release
// ============================================================================
module w_mem_load_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 9
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              clear,
  input  wire logic              start,
  input  wire logic [2:0]        cfg_mode,
  input  wire logic [ADDR_W-1:0] cfg_base_addr,
  input  wire logic [CNT_W-1:0]  cfg_num_words,
  w_mem_load_ctrl_if.master      bus,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       words_written
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              cnn_q, cnn_d;       // latched port select
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;       // beats accepted in this job
  logic              en_cnn_q, en_cnn_d;
  logic [ADDR_W-1:0] addr_cnn_q, addr_cnn_d;
  logic [DATA_W-1:0] data_cnn_q, data_cnn_d;
  logic              en_fc_q, en_fc_d;
  logic [ADDR_W-1:0] addr_fc_q, addr_fc_d;
  logic [DATA_W-1:0] data_fc_q, data_fc_d;

  logic              handshake;
  logic [ADDR_W-1:0] next_addr;

  // Ready is a pure state decode, so it never depends on in_valid.
  assign handshake = (state_q == S_LOAD) && bus.in_valid;
  // Address arithmetic truncates to ADDR_W, which gives the 255->0 wrap.
  assign next_addr = base_q + cnt_q[ADDR_W-1:0];

  always_comb begin
    state_d    = state_q;
    cnn_d      = cnn_q;
    base_d     = base_q;
    num_d      = num_q;
    cnt_d      = cnt_q;
    en_cnn_d   = 1'b0;
    addr_cnn_d = addr_cnn_q;
    data_cnn_d = data_cnn_q;
    en_fc_d    = 1'b0;
    addr_fc_d  = addr_fc_q;
    data_fc_d  = data_fc_q;

    if (clear) begin
      // Abort: no write, counter kept for inspection.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnn_d   = (cfg_mode == 3'd1);
            base_d  = cfg_base_addr;
            num_d   = cfg_num_words;
            cnt_d   = '0;
            state_d = (cfg_num_words == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          if (handshake) begin
            if (cnn_q) begin
              en_cnn_d   = 1'b1;
              addr_cnn_d = next_addr;
              data_cnn_d = bus.in_data;
            end else begin
              en_fc_d    = 1'b1;
              addr_fc_d  = next_addr;
              data_fc_d  = bus.in_data;
            end
            cnt_d = cnt_q + CNT_W'(1);
            // num_q >= 1 here, so num_q-1 cannot underflow.
            if (cnt_q == (num_q - CNT_W'(1))) begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnn_q      <= 1'b0;
      base_q     <= '0;
      num_q      <= '0;
      cnt_q      <= '0;
      en_cnn_q   <= 1'b0;
      addr_cnn_q <= '0;
      data_cnn_q <= '0;
      en_fc_q    <= 1'b0;
      addr_fc_q  <= '0;
      data_fc_q  <= '0;
    end else begin
      cnn_q      <= cnn_d;
      base_q     <= base_d;
      num_q      <= num_d;
      cnt_q      <= cnt_d;
      en_cnn_q   <= en_cnn_d;
      addr_cnn_q <= addr_cnn_d;
      data_cnn_q <= data_cnn_d;
      en_fc_q    <= en_fc_d;
      addr_fc_q  <= addr_fc_d;
      data_fc_q  <= data_fc_d;
    end
  end

  assign bus.in_ready      = (state_q == S_LOAD);
  assign bus.wr_enable_cnn = en_cnn_q;
  assign bus.wr_addr_cnn   = addr_cnn_q;
  assign bus.wr_data_cnn   = data_cnn_q;
  assign bus.wr_enable_fc  = en_fc_q;
  assign bus.wr_addr_fc    = addr_fc_q;
  assign bus.wr_data_fc    = data_fc_q;
  assign busy              = (state_q != S_IDLE);
  assign done              = (state_q == S_DONE);
  assign words_written     = cnt_q;

endmodule
`default_nettype wire
